// File: rtl/ec_scalar_mul_ctrl.sv
// Double-and-add-always scalar multiplication sequencer (Q = k*P).
// Drives one external point add/double engine through a start/finish handshake.
module ec_scalar_mul_ctrl #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_px,
  input  logic [WIDTH-1:0] i_py,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_op_start,
  output logic             o_op_dbl,
  output logic             o_op_add,
  output logic [WIDTH-1:0] o_op_x1,
  output logic [WIDTH-1:0] o_op_y1,
  output logic [WIDTH-1:0] o_op_x2,
  output logic [WIDTH-1:0] o_op_y2,
  input  logic             i_op_finish,
  input  logic [WIDTH-1:0] i_op_x,
  input  logic [WIDTH-1:0] i_op_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL_ISS, S_DBL_WAIT, S_ADD_ISS, S_ADD_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] k_q, k_d, px_q, px_d, py_q, py_d, rx_q, rx_d, ry_q, ry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d, finished_q, finished_d;
  logic [WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic             op_start_q, op_start_d, op_dbl_q, op_dbl_d, op_add_q, op_add_d;
  logic [WIDTH-1:0] op_x1_q, op_x1_d, op_y1_q, op_y1_d, op_x2_q, op_x2_d, op_y2_q, op_y2_d;

  logic [WIDTH-1:0] k_shift;
  logic             k_bit;
  logic             idx_zero;
  logic             op_done;

  assign k_shift  = k_q >> idx_q;
  assign k_bit    = k_shift[0];
  assign idx_zero = (idx_q == '0);
  // A finish coinciding with our own start pulse cannot belong to this op.
  assign op_done  = i_op_finish && !op_start_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    px_d       = px_q;
    py_d       = py_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    idx_d      = idx_q;
    finished_d = 1'b0;
    op_start_d = 1'b0;
    res_x_d    = res_x_q;
    res_y_d    = res_y_q;
    op_dbl_d   = op_dbl_q;
    op_add_d   = op_add_q;
    op_x1_d    = op_x1_q;
    op_y1_d    = op_y1_q;
    op_x2_d    = op_x2_q;
    op_y2_d    = op_y2_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d   = i_k;
          px_d  = i_px;
          py_d  = i_py;
          idx_d = CNT_W'(WIDTH - 1);
          if ((&i_px) || (i_k == '0)) begin
            rx_d    = '1;
            ry_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (k_bit) begin
          rx_d = px_q;
          ry_d = py_q;
          if (idx_zero) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - CNT_W'(1);
            state_d = S_DBL_ISS;
          end
        end else if (idx_zero) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      S_DBL_ISS: begin
        op_start_d = 1'b1;
        op_dbl_d   = 1'b1;
        op_add_d   = 1'b1;
        op_x1_d    = rx_q;
        op_y1_d    = ry_q;
        op_x2_d    = rx_q;
        op_y2_d    = ry_q;
        state_d    = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (op_done) begin
          rx_d    = i_op_x;
          ry_d    = i_op_y;
          state_d = S_ADD_ISS;
        end
      end
      S_ADD_ISS: begin
        // Add is always issued; the commit flag decides whether R changes.
        op_start_d = 1'b1;
        op_dbl_d   = 1'b0;
        op_add_d   = k_bit;
        op_x1_d    = rx_q;
        op_y1_d    = ry_q;
        op_x2_d    = px_q;
        op_y2_d    = py_q;
        state_d    = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (op_done) begin
          rx_d    = i_op_x;
          ry_d    = i_op_y;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_zero) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - CNT_W'(1);
          state_d = S_DBL_ISS;
        end
      end
      S_DONE: begin
        finished_d = 1'b1;
        res_x_d    = rx_q;
        res_y_d    = ry_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      op_start_q <= 1'b0;
      op_dbl_q   <= 1'b0;
      op_add_q   <= 1'b0;
      op_x1_q    <= '0;
      op_y1_q    <= '0;
      op_x2_q    <= '0;
      op_y2_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      res_x_q    <= res_x_d;
      res_y_q    <= res_y_d;
      op_start_q <= op_start_d;
      op_dbl_q   <= op_dbl_d;
      op_add_q   <= op_add_d;
      op_x1_q    <= op_x1_d;
      op_y1_q    <= op_y1_d;
      op_x2_q    <= op_x2_d;
      op_y2_q    <= op_y2_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_finished = finished_q;
  assign o_result_x = res_x_q;
  assign o_result_y = res_y_q;
  assign o_op_start = op_start_q;
  assign o_op_dbl   = op_dbl_q;
  assign o_op_add   = op_add_q;
  assign o_op_x1    = op_x1_q;
  assign o_op_y1    = op_y1_q;
  assign o_op_x2    = op_x2_q;
  assign o_op_y2    = op_y2_q;

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Bench for ec_scalar_mul_ctrl: behavioural engine on y^2 = x^3 + 2x + 3 mod 97,
// with queued expected op flags and results.
module tb_ec_scalar_mul_ctrl;
  localparam int W = 256;
  localparam int PR = 97;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pt_t;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_k = '0, i_px = '0, i_py = '0;
  logic         o_busy, o_finished, o_op_start, o_op_dbl, o_op_add;
  logic [W-1:0] o_result_x, o_result_y, o_op_x1, o_op_y1, o_op_x2, o_op_y2;
  logic         i_op_finish;
  logic [W-1:0] i_op_x = '0, i_op_y = '0;
  logic         eng_fin = 1'b0, stale_fin = 1'b0;

  int checks = 0;
  int errors = 0;
  int ops_seen = 0;
  int fin_count = 0;
  int eng_cnt = 0;
  int cur_px = 0, cur_py = 0;
  int cyc;
  logic [W-1:0] pend_x, pend_y;
  pt_t          exp_res[$];
  logic [1:0]   exp_ops[$];

  assign i_op_finish = eng_fin | stale_fin;

  ec_scalar_mul_ctrl #(.WIDTH(W), .CNT_W(9)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_k(i_k), .i_px(i_px), .i_py(i_py),
    .o_busy(o_busy), .o_finished(o_finished), .o_result_x(o_result_x), .o_result_y(o_result_y),
    .o_op_start(o_op_start), .o_op_dbl(o_op_dbl), .o_op_add(o_op_add),
    .o_op_x1(o_op_x1), .o_op_y1(o_op_y1), .o_op_x2(o_op_x2), .o_op_y2(o_op_y2),
    .i_op_finish(i_op_finish), .i_op_x(i_op_x), .i_op_y(i_op_y)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int md(input int a);
    int r = a % PR;
    return (r < 0) ? r + PR : r;
  endfunction

  function automatic int inv(input int a);
    int r = 1;
    int b = md(a);
    for (int e = PR - 2; e > 0; e = e >> 1) begin
      if (e[0]) r = md(r * b);
      b = md(b * b);
    end
    return r;
  endfunction

  // Affine point add/double; x < 0 encodes the point at infinity.
  task automatic pt_add(input int x1, y1, x2, y2, output int x3, y3);
    int l;
    if (x1 < 0) begin x3 = x2; y3 = y2; end
    else if (x2 < 0) begin x3 = x1; y3 = y1; end
    else if (x1 == x2 && md(y1 + y2) == 0) begin x3 = -1; y3 = -1; end
    else begin
      if (x1 == x2) l = md(md(3 * x1 * x1 + 2) * inv(2 * y1));
      else l = md(md(y2 - y1) * inv(x2 - x1));
      x3 = md(l * l - x1 - x2);
      y3 = md(l * (x1 - x3) - y1);
    end
  endtask

  function automatic logic [W-1:0] to_vec(input int v);
    return (v < 0) ? {W{1'b1}} : W'(unsigned'(v));
  endfunction

  function automatic int to_int(input logic [W-1:0] v);
    return (&v) ? -1 : int'(v[31:0]);
  endfunction

  // Behavioural engine plus result/op scoreboard, sampled on the falling edge.
  always @(negedge i_clk) begin
    int x3, y3;
    logic [1:0] e;
    pt_t r;
    eng_fin = 1'b0;
    if (!i_rst) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_fin = 1'b1;
          i_op_x  = pend_x;
          i_op_y  = pend_y;
        end
      end
      if (o_op_start) begin
        ops_seen++;
        if (exp_ops.size() == 0) chk("op_unexpected", 1, 0);
        else begin
          e = exp_ops.pop_front();
          chk("op_flags", {o_op_dbl, o_op_add}, e);
          if (!o_op_dbl) chk("add_operand_p", {o_op_x2[31:0], o_op_y2[31:0]},
                             {to_vec(cur_px)[31:0], to_vec(cur_py)[31:0]});
        end
        if (o_op_dbl)
          pt_add(to_int(o_op_x1), to_int(o_op_y1), to_int(o_op_x1), to_int(o_op_y1), x3, y3);
        else if (o_op_add)
          pt_add(to_int(o_op_x1), to_int(o_op_y1), to_int(o_op_x2), to_int(o_op_y2), x3, y3);
        else begin
          x3 = to_int(o_op_x1);
          y3 = to_int(o_op_y1);
        end
        pend_x  = to_vec(x3);
        pend_y  = to_vec(y3);
        eng_cnt = 3;
      end
    end
    if (o_finished) begin
      fin_count++;
      if (exp_res.size() == 0) chk("finish_unexpected", 1, 0);
      else begin
        r = exp_res.pop_front();
        chk("result_x", o_result_x, r.x);
        chk("result_y", o_result_y, r.y);
      end
    end
  end

  // Queue expectations, then pulse i_start across one rising edge.
  task automatic issue(input int k, input int px, input int py);
    int rx = -1, ry = -1, lead = -1;
    logic [31:0] kb;
    pt_t r;
    kb = 32'(k);
    if (px >= 0) begin
      for (int i = 0; i < k; i++) pt_add(rx, ry, px, py, rx, ry);
      for (int i = 0; i < 32; i++) if (kb[i]) lead = i;
      for (int i = lead - 1; i >= 0; i--) begin
        exp_ops.push_back(2'b11);
        exp_ops.push_back({1'b0, kb[i]});
      end
    end
    r.x = to_vec(rx);
    r.y = to_vec(ry);
    exp_res.push_back(r);
    cur_px   = px;
    cur_py   = py;
    ops_seen = 0;
    @(negedge i_clk);
    i_k = W'(k); i_px = to_vec(px); i_py = to_vec(py); i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Counts rising edges from the accepting edge until o_finished is seen.
  task automatic wait_fin(input int poke, output int n);
    n = 1;
    while (!o_finished && n < 2000) begin
      @(posedge i_clk);
      #1 n++;
      if (poke > 0 && n == poke) begin i_start = 1'b1; i_k = W'(7); end
      if (poke > 0 && n == poke + 1) i_start = 1'b0;
    end
    chk("finish_seen", o_finished, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_finished"}, o_finished, 0);
    chk({tag, "_op_start"}, {o_op_start, o_op_dbl, o_op_add}, 0);
    chk({tag, "_result"}, o_result_x | o_result_y, 0);
    chk({tag, "_operands"}, o_op_x1 | o_op_y1 | o_op_x2 | o_op_y2, 0);
  endtask

  initial begin
    int fc, n;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst = 1'b1;

    issue(0, 3, 6);
    wait_fin(0, cyc);
    chk("k0_latency", cyc, 2);
    chk("k0_ops", ops_seen, 0);

    issue(1, 3, 6);
    wait_fin(0, cyc);
    chk("k1_latency", cyc, W + 2);
    chk("k1_ops", ops_seen, 0);

    issue(2, 3, 6);
    wait_fin(0, cyc);
    chk("k2_ops", ops_seen, 2);
    chk("k2_x_const", o_result_x, 80);
    chk("k2_y_const", o_result_y, 10);

    issue(5, 3, 6);
    wait_fin(W + 5, cyc);
    chk("k5_ops", ops_seen, 4);

    issue(5, -1, -1);
    wait_fin(0, cyc);
    chk("pinf_ops", ops_seen, 0);

    // Reset while the first double op is outstanding.
    issue(2, 3, 6);
    n = 0;
    while (!o_op_start && n < 2000) begin @(posedge i_clk); #1 n++; end
    chk("rst_op_seen", o_op_start, 1);
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    #1 chk_zero("midrst");
    exp_res.delete();
    exp_ops.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    fc = fin_count;
    @(negedge i_clk) stale_fin = 1'b1;
    @(negedge i_clk) stale_fin = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("stale_no_finish", fin_count, fc);
    chk_zero("stale");

    issue(2, 3, 6);
    wait_fin(0, cyc);
    chk("k2b_ops", ops_seen, 2);
    chk("k2b_x_const", o_result_x, 80);
    chk("k2b_y_const", o_result_y, 10);

    repeat (3) @(negedge i_clk);
    chk("queue_empty", exp_res.size() + exp_ops.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
